// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer SRAM arbiter: state encoding,
// default bus widths, active-low strobe levels and requester IDs.
package fb_pkg;

    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } fb_state_e;

    // Plain vector forms of the states for the sequencer's state register.
    localparam logic [1:0] ST_IDLE   = S_IDLE;
    localparam logic [1:0] ST_ACCESS = S_ACCESS;
    localparam logic [1:0] ST_DONE   = S_DONE;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam logic REQ_DISP = 1'b0;
    localparam logic REQ_CPU  = 1'b1;

endpackage

// File: rtl/sram_access_seq.sv
// Runs one timed SRAM access (ACCESS for ACCESS_CYCLES cycles, then DONE)
// from a request latched on i_start, driving every SRAM pin from registers.
module sram_access_seq
    import fb_pkg::*;
#(
    parameter int ADDR_W        = FB_ADDR_W,
    parameter int DATA_W        = FB_DATA_W,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_be,
    input  logic              i_write,
    output logic              o_idle,
    output logic              o_last_access,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_data_oe,
    output logic              o_ce,
    output logic              o_oe,
    output logic              o_wr,
    output logic              o_ub,
    output logic              o_lb
);

    localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_data_oe;
    logic              r_ce;
    logic              r_oe;
    logic              r_wr;
    logic              r_ub;
    logic              r_lb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_data_oe <= 1'b0;
            r_ce      <= STROBE_OFF;
            r_oe      <= STROBE_OFF;
            r_wr      <= STROBE_OFF;
            r_ub      <= STROBE_OFF;
            r_lb      <= STROBE_OFF;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= '0;
                        r_write <= i_write;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_ce    <= STROBE_ON;
                        // WR stays off for the first cycle so the address settles first.
                        r_wr    <= STROBE_OFF;
                        if (i_write) begin
                            r_oe      <= STROBE_OFF;
                            r_data_oe <= 1'b1;
                            r_ub      <= ~i_be[1];
                            r_lb      <= ~i_be[0];
                        end else begin
                            r_oe      <= STROBE_ON;
                            r_data_oe <= 1'b0;
                            r_ub      <= STROBE_ON;
                            r_lb      <= STROBE_ON;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_DONE;
                        r_ce    <= STROBE_OFF;
                        r_oe    <= STROBE_OFF;
                        r_wr    <= STROBE_OFF;
                        r_ub    <= STROBE_OFF;
                        r_lb    <= STROBE_OFF;
                        // DATA_OE deliberately untouched: write data is held through DONE.
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_write) begin
                            r_wr <= STROBE_ON;
                        end
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_data_oe <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_data_oe <= 1'b0;
                end
            endcase
        end
    end

    assign o_idle        = (r_state == ST_IDLE);
    assign o_last_access = (r_state == ST_ACCESS) && (r_cnt == LAST_CNT);
    assign o_write       = r_write;
    assign o_addr        = r_addr;
    assign o_wdata       = r_wdata;
    assign o_data_oe     = r_data_oe;
    assign o_ce          = r_ce;
    assign o_oe          = r_oe;
    assign o_wr          = r_wr;
    assign o_ub          = r_ub;
    assign o_lb          = r_lb;

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer SRAM arbiter: display-priority grant with a CPU starvation
// bound, ack/rdata routing, and a sequencer that owns the SRAM pins.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W        = FB_ADDR_W,
    parameter int DATA_W        = FB_DATA_W,
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_MAX    = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_be,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    output logic [ADDR_W-1:0] ADDRESS_PINS,
    output logic [DATA_W-1:0] DATA_OUT_PINS,
    input  logic [DATA_W-1:0] DATA_IN_PINS,
    output logic              DATA_OE,
    output logic              CE,
    output logic              OE,
    output logic              WR,
    output logic              UB,
    output logic              LB,
    output logic              busy
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    logic                r_grant_id;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_cpu_ack;
    logic                r_disp_ack;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_disp_rdata;

    logic                w_seq_idle;
    logic                w_last_access;
    logic                w_seq_write;
    logic                w_cpu_win;
    logic                w_start;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [1:0]          w_req_be;
    logic                w_req_write;

    // CPU only beats a pending display request once the starvation bound is hit.
    assign w_cpu_win   = cpu_req && (!disp_req || (r_starve_cnt == STARVE_LIMIT));
    assign w_start     = w_seq_idle && (cpu_req || disp_req);
    assign w_req_addr  = w_cpu_win ? cpu_addr : disp_addr;
    assign w_req_be    = w_cpu_win ? cpu_be : 2'b11;
    assign w_req_write = w_cpu_win && cpu_write;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_grant_id   <= REQ_DISP;
            r_starve_cnt <= '0;
            r_cpu_ack    <= 1'b0;
            r_disp_ack   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_disp_rdata <= '0;
        end else begin
            r_cpu_ack  <= 1'b0;
            r_disp_ack <= 1'b0;
            if (w_seq_idle) begin
                if (!cpu_req || w_cpu_win) begin
                    r_starve_cnt <= '0;
                end else if (r_starve_cnt != STARVE_LIMIT) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
                if (w_start) begin
                    r_grant_id <= w_cpu_win ? REQ_CPU : REQ_DISP;
                end
            end
            if (w_last_access) begin
                if (r_grant_id == REQ_CPU) begin
                    r_cpu_ack <= 1'b1;
                    if (!w_seq_write) begin
                        r_cpu_rdata <= DATA_IN_PINS;
                    end
                end else begin
                    r_disp_ack   <= 1'b1;
                    r_disp_rdata <= DATA_IN_PINS;
                end
            end
        end
    end

    sram_access_seq #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_seq (
        .clk           (CLK),
        .rst_n         (RESET_N),
        .i_start       (w_start),
        .i_addr        (w_req_addr),
        .i_wdata       (cpu_wdata),
        .i_be          (w_req_be),
        .i_write       (w_req_write),
        .o_idle        (w_seq_idle),
        .o_last_access (w_last_access),
        .o_write       (w_seq_write),
        .o_addr        (ADDRESS_PINS),
        .o_wdata       (DATA_OUT_PINS),
        .o_data_oe     (DATA_OE),
        .o_ce          (CE),
        .o_oe          (OE),
        .o_wr          (WR),
        .o_ub          (UB),
        .o_lb          (LB)
    );

    assign cpu_ack    = r_cpu_ack;
    assign disp_ack   = r_disp_ack;
    assign cpu_rdata  = r_cpu_rdata;
    assign disp_rdata = r_disp_rdata;
    assign busy       = !w_seq_idle;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: model SRAM, slot-based reference
// arbiter and memory, table vectors, reset abort, starvation and random traffic.
module tb_fb_arbiter;

    localparam int STARVE_MAX = 8;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        cpu_req, cpu_write;
    logic [15:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_be;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic        disp_ack;
    logic [15:0] disp_rdata;
    logic [15:0] ADDRESS_PINS, DATA_OUT_PINS, DATA_IN_PINS;
    logic        DATA_OE, CE, OE, WR, UB, LB, busy;

    fb_arbiter #(
        .ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(2), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rdata(disp_rdata),
        .ADDRESS_PINS(ADDRESS_PINS), .DATA_OUT_PINS(DATA_OUT_PINS), .DATA_IN_PINS(DATA_IN_PINS),
        .DATA_OE(DATA_OE), .CE(CE), .OE(OE), .WR(WR), .UB(UB), .LB(LB), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Model asynchronous SRAM pads.
    logic [15:0] sram_mem [0:65535];
    assign DATA_IN_PINS = sram_mem[ADDRESS_PINS];
    always @(posedge CLK) begin
        if (!CE && !WR) begin
            if (!UB) sram_mem[ADDRESS_PINS][15:8] <= DATA_OUT_PINS[15:8];
            if (!LB) sram_mem[ADDRESS_PINS][7:0]  <= DATA_OUT_PINS[7:0];
        end
    end

    // Reference state: expected memory contents and arbitration bookkeeping.
    logic [15:0] ref_mem [0:65535];
    bit          disp_pend, cpu_pend;
    int          streak;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic ref_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        if (be[1]) ref_mem[a][15:8] = d[15:8];
        if (be[0]) ref_mem[a][7:0]  = d[7:0];
    endtask

    // One arbitration slot: called #1 after the edge that enters IDLE.
    task automatic slot(input bit nd, input logic [15:0] da,
                        input bit nc, input bit cw, input logic [15:0] ca,
                        input logic [15:0] cd, input logic [1:0] cbe,
                        output int win, output logic [15:0] got);
        logic        w_wr;
        logic [15:0] w_addr;
        logic [1:0]  w_be;
        logic [5:0]  exp_pins;
        if (!disp_pend) begin
            if (nd) begin disp_pend = 1; disp_addr = da; disp_req = 1; end
            else disp_req = 0;
        end
        if (!cpu_pend) begin
            if (nc) begin
                cpu_pend = 1; cpu_write = cw; cpu_addr = ca; cpu_wdata = cd; cpu_be = cbe; cpu_req = 1;
            end else cpu_req = 0;
        end
        if (!cpu_pend) streak = 0;
        win = 0;
        if (cpu_pend && (!disp_pend || streak == STARVE_MAX)) begin
            win = 2; streak = 0;
        end else if (disp_pend) begin
            win = 1;
            if (cpu_pend) streak++;
        end
        got = '0;
        if (win == 0) begin
            @(negedge CLK);
            check("idle_busy", busy, 0);
            check("idle_acks", {cpu_ack, disp_ack}, 2'b00);
            @(posedge CLK); #1;
            return;
        end
        w_wr   = (win == 2) && cpu_write;
        w_addr = (win == 2) ? cpu_addr : disp_addr;
        w_be   = (win == 2) ? cpu_be : 2'b11;
        for (int n = 1; n <= 4; n++) begin
            @(negedge CLK);
            check("acks", {cpu_ack, disp_ack}, {(n == 4 && win == 2), (n == 4 && win == 1)});
            check("busy", busy, (n != 1));
            if (n == 2 || n == 3) begin
                exp_pins = {1'b0, w_wr, !(w_wr && n == 3),
                            w_wr ? ~w_be[1] : 1'b0, w_wr ? ~w_be[0] : 1'b0, w_wr};
                check("access_pins", {CE, OE, WR, UB, LB, DATA_OE}, exp_pins);
                check("access_addr", ADDRESS_PINS, w_addr);
                if (w_wr) check("access_wdata", DATA_OUT_PINS, cpu_wdata);
            end else begin
                check("strobes_off", {CE, OE, WR, UB, LB, DATA_OE}, {5'h1f, (n == 4) && w_wr});
            end
            if (n == 4) begin
                got = (win == 2) ? cpu_rdata : disp_rdata;
                if (w_wr) ref_write(w_addr, cpu_wdata, w_be);
                else check(win == 2 ? "cpu_rdata" : "disp_rdata", got, ref_mem[w_addr]);
            end
        end
        if (win == 2) cpu_pend = 0; else disp_pend = 0;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [7];
        int          win, cpu_grants;
        logic [15:0] got;
        int          n;

        tbl[0] = '{1, 16'h0123, 16'hBEEF, 2'b11, 16'h0000};
        tbl[1] = '{0, 16'h0123, 16'h0000, 2'b11, 16'hBEEF};
        tbl[2] = '{1, 16'h0123, 16'h55AA, 2'b01, 16'h0000};
        tbl[3] = '{0, 16'h0123, 16'h0000, 2'b11, 16'hBEAA};
        tbl[4] = '{1, 16'h0200, 16'h1234, 2'b10, 16'h0000};
        tbl[5] = '{0, 16'h0200, 16'h0000, 2'b11, 16'h1200};
        tbl[6] = '{0, 16'h0123, 16'h0000, 2'b11, 16'hBEAA};

        for (int i = 0; i < 65536; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
        cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
        disp_req = 0; disp_addr = 0;
        disp_pend = 0; cpu_pend = 0; streak = 0;

        // Reset state
        RESET_N = 0;
        repeat (2) @(negedge CLK);
        check("rst_strobes", {CE, OE, WR, UB, LB, DATA_OE}, 6'b111110);
        check("rst_pins", {ADDRESS_PINS, DATA_OUT_PINS}, 32'h0);
        check("rst_acks_busy", {cpu_ack, disp_ack, busy}, 3'b000);
        check("rst_rdata", {cpu_rdata, disp_rdata}, 32'h0);
        RESET_N = 1;
        @(posedge CLK); #1;

        // Table vectors, CPU only
        foreach (tbl[i]) begin
            slot(0, 16'h0, 1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, win, got);
            check("tbl_win", win, 2);
            if (!tbl[i].wr) check("tbl_rdata", got, tbl[i].exp);
        end

        // Back-to-back CPU reads with req held, then busy must be low
        for (int a = 0; a < 4; a++) begin
            slot(0, 16'h0, 1, 0, 16'(a), 16'h0, 2'b11, win, got);
            check("b2b_win", win, 2);
        end
        slot(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, win, got);

        // Reset during the second ACCESS cycle of a write
        cpu_req = 1; cpu_write = 1; cpu_addr = 16'h0300; cpu_wdata = 16'h7777; cpu_be = 2'b11;
        repeat (3) @(negedge CLK);
        check("pre_abort_wr", WR, 0);
        RESET_N = 0;
        #1;
        check("abort_strobes", {CE, OE, WR, UB, LB, DATA_OE}, 6'b111110);
        check("abort_ack_busy", {cpu_ack, disp_ack, busy}, 3'b000);
        @(negedge CLK);
        check("abort_no_ack", cpu_ack, 0);
        RESET_N = 1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!cpu_ack && n < 10);
        check("restart_ack_latency", n, 3);
        ref_write(16'h0300, 16'h7777, 2'b11);
        streak = 0;
        @(posedge CLK); #1;
        slot(0, 16'h0, 1, 0, 16'h0300, 16'h0, 2'b11, win, got);
        check("restart_rdata", got, 16'h7777);
        slot(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, win, got);

        // Both requesters held: 8 display grants then 1 CPU grant, repeating
        cpu_grants = 0;
        for (int s = 1; s <= 27; s++) begin
            slot(1, 16'(s), 1, 0, 16'(s + 100), 16'h0, 2'b11, win, got);
            if (win == 2) begin
                cpu_grants++;
                check("starve_cpu_slot", s % 9, 0);
            end
        end
        check("starve_cpu_count", cpu_grants, 3);
        disp_pend = 0;
        slot(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, win, got);

        // Random mixed traffic
        for (int s = 0; s < 200; s++) begin
            slot(($urandom % 4) != 0, 16'($urandom_range(0, 31)),
                 ($urandom % 2) == 1, ($urandom % 2) == 1, 16'($urandom_range(0, 31)),
                 16'($urandom), 2'($urandom), win, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
